// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: memory request/response, decode handshake, redirect and halt signals of the fetch stage.
// master is the fetch stage; slave is its surroundings (memory, decode, execute).
interface instruction_fetch_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        halted;

    modport master (
        output mem_req_valid, mem_req_addr, out_valid, out_instr, out_pc, halted,
        input  mem_req_ready, mem_resp_valid, mem_resp_data, out_ready, redirect_valid, redirect_pc, halt
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, out_valid, out_instr, out_pc, halted,
        output mem_req_ready, mem_resp_valid, mem_resp_data, out_ready, redirect_valid, redirect_pc, halt
    );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: in-order fetch stage with credit-limited requests, {word, PC} FIFO, redirect flush and halt.
// Define FETCH_MISALIGN_TRAP_EN to halt on a misaligned redirect target instead of aligning it.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input logic                 clk,
    input logic                 reset_n,
    instruction_fetch_if.master bus
);
    localparam int            AW   = $clog2(DEPTH);
    localparam int            CW   = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {RUN, HALTED} state_t;

    state_t        r_state, w_state_nxt;
    logic [31:0]   r_pc, w_pc_nxt, w_target;
    logic [CW-1:0] r_out, r_drop, r_cnt;
    logic [AW-1:0] r_qw, r_qr, r_fw, r_fr;
    logic [31:0]   r_pcq [DEPTH];
    logic [31:0]   r_fi  [DEPTH];
    logic [31:0]   r_fp  [DEPTH];
    logic          w_req_valid, w_fire, w_keep, w_pop, w_drop_resp, w_misalign;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign w_target   = bus.redirect_pc;
    assign w_misalign = |bus.redirect_pc[1:0];
`else
    assign w_target   = bus.redirect_pc & ~32'h3;
    assign w_misalign = 1'b0;
`endif

    assign w_fire      = w_req_valid & bus.mem_req_ready;
    assign w_drop_resp = bus.mem_resp_valid & (r_drop != '0);
    assign w_keep      = bus.mem_resp_valid & (r_drop == '0) & !bus.redirect_valid;
    assign w_pop       = (r_cnt != '0) & bus.out_ready;

    // Credits count both in-flight requests and buffered words, so a response always finds room.
    always_comb begin
        w_req_valid = (r_state == RUN) & !bus.redirect_valid & (r_out + r_cnt < FULL);
        w_state_nxt = bus.redirect_valid ? (w_misalign ? HALTED : RUN) : bus.halt ? HALTED : r_state;
        w_pc_nxt    = bus.redirect_valid ? w_target : w_fire ? r_pc + 32'd4 : r_pc;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= RUN;
            r_pc    <= RESET_PC;
            r_out   <= '0;
            r_drop  <= '0;
            r_cnt   <= '0;
            r_qw    <= '0;
            r_qr    <= '0;
            r_fw    <= '0;
            r_fr    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_out   <= r_out + CW'(w_fire) - CW'(bus.mem_resp_valid);
            r_drop  <= bus.redirect_valid ? r_out - CW'(bus.mem_resp_valid) : r_drop - CW'(w_drop_resp);
            r_cnt   <= bus.redirect_valid ? '0 : r_cnt + CW'(w_keep) - CW'(w_pop);
            r_qw    <= r_qw + AW'(w_fire);
            r_qr    <= r_qr + AW'(bus.mem_resp_valid);
            r_fw    <= bus.redirect_valid ? '0 : r_fw + AW'(w_keep);
            r_fr    <= bus.redirect_valid ? '0 : r_fr + AW'(w_pop);
        end
    end

    // The PC queue survives redirects so that stale responses still pop their own entry.
    always_ff @(posedge clk) begin
        if (w_fire) r_pcq[r_qw] <= r_pc;
        if (w_keep) begin
            r_fi[r_fw] <= bus.mem_resp_data;
            r_fp[r_fw] <= r_pcq[r_qr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!(w_keep && r_cnt == FULL)) else $error("instruction_fetch: FIFO overflow");
`ifdef FETCH_MISALIGN_TRAP_EN
            assert (!(bus.redirect_valid && w_misalign)) else $error("instruction_fetch: misaligned redirect");
`endif
        end
    end

    assign bus.mem_req_valid = w_req_valid;
    assign bus.mem_req_addr  = r_pc;
    assign bus.out_valid     = r_cnt != '0;
    assign bus.out_instr     = bus.out_valid ? r_fi[r_fr] : '0;
    assign bus.out_pc        = bus.out_valid ? r_fp[r_fr] : '0;
    assign bus.halted        = r_state == HALTED;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: randomized bench for instruction_fetch against a queue-based reference model.
// Memory returns word(addr) after a programmable latency; the model predicts every output each cycle.
module tb_instruction_fetch;
    localparam logic [31:0] RPC   = 32'h0000_0100;
    localparam int          DEPTH = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    instruction_fetch_if bus();

    instruction_fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    typedef struct packed { logic [31:0] pc; logic drop; } ent_t;
    typedef struct packed { int due; logic [31:0] addr; } mreq_t;

    ent_t        oq[$];
    logic [31:0] fq[$];
    mreq_t       mq[$];
    logic [31:0] m_pc;
    bit          m_halt, just_rst;
    int          cyc, lat, last_due, n_chk, n_pass;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h7F4A_7C15;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then advance the model and memory.
    task automatic step(input bit rv, input logic [31:0] rpc, input bit h, input bit rn, input bit rdy, input bit ordy);
        bit          rsp, exp_rv, dfire;
        logic [31:0] daddr;
        ent_t        e;
        int          due;
        @(negedge clk);
        reset_n            = rn;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.halt           = h;
        bus.mem_req_ready  = rdy;
        bus.out_ready      = ordy;
        rsp                = mq.size() > 0 && mq[0].due <= cyc;
        bus.mem_resp_valid = rsp;
        bus.mem_resp_data  = rsp ? word(mq[0].addr) : $urandom;
        #1;
        exp_rv = !m_halt && !rv && (oq.size() + fq.size() < DEPTH);
        check("req_valid", 32'(bus.mem_req_valid), 32'(exp_rv));
        if (exp_rv) check("req_addr", bus.mem_req_addr, m_pc);
        check("out_valid", 32'(bus.out_valid), 32'(fq.size() > 0));
        if (fq.size() > 0) begin
            check("out_pc", bus.out_pc, fq[0]);
            check("out_instr", bus.out_instr, word(fq[0]));
        end else if (just_rst) begin
            check("rst_out_pc", bus.out_pc, 32'h0);
            check("rst_out_instr", bus.out_instr, 32'h0);
        end
        check("halted", 32'(bus.halted), 32'(m_halt));
        dfire = bus.mem_req_valid && rdy;
        daddr = bus.mem_req_addr;
        if (!rn) begin
            oq.delete();
            fq.delete();
            mq.delete();
            m_pc     = RPC;
            m_halt   = 1'b0;
            last_due = cyc;
        end else begin
            if (fq.size() > 0 && ordy) void'(fq.pop_front());
            if (rsp && oq.size() > 0) begin
                e = oq.pop_front();
                if (!e.drop && !rv) fq.push_back(e.pc);
            end
            if (exp_rv && rdy) begin
                oq.push_back('{m_pc, 1'b0});
                m_pc += 32'd4;
            end
            if (rv) begin
                fq.delete();
                foreach (oq[i]) oq[i].drop = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
                m_pc   = rpc;
                m_halt = rpc[1:0] != 2'b00;
`else
                m_pc   = rpc & ~32'h3;
                m_halt = 1'b0;
`endif
            end else if (h) m_halt = 1'b1;
            if (rsp) void'(mq.pop_front());
            if (dfire) begin
                due      = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                last_due = due;
                mq.push_back('{due, daddr});
            end
        end
        just_rst = !rn;
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic redir(input logic [31:0] pc);
        step(1'b1, pc, 1'b0, 1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.halt           = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        bus.out_ready      = 1'b0;
        m_pc = RPC; m_halt = 1'b0; cyc = 0; lat = 1; last_due = 0; n_chk = 0; n_pass = 0;
        repeat (2) @(posedge clk);
        just_rst = 1'b1;
        // streaming from RESET_PC with single-cycle memory
        run(20);
        // decode stall then release
        repeat (5) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        run(10);
        // slow memory, redirect with two requests in flight
        lat = 3;
        redir(32'h10);
        run(2);
        redir(32'h200);
        run(12);
        // halt after a request, then resume via redirect
        lat = 1;
        redir(32'h20);
        run(1);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
        run(5);
        redir(32'h40);
        run(6);
        // misaligned target and address wrap
        redir(32'h203);
        run(6);
        redir(32'hFFFF_FFF8);
        run(6);
        // reset with a stalled, full FIFO
        lat = 2;
        repeat (4) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        run(8);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) lat = $urandom_range(1, 4);
            step($urandom_range(0, 19) == 0,
                 ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 | ($urandom & 32'hF) : $urandom & 32'h0000_0FFF,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 255) != 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) != 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
